car_sequencer: RTL and testbench

Owns the registered Control Address Register (CAR) that indexes the microcode ROM, and sequences it through reset, normal microsequences (uSeqs), memory wait-state stalls, interrupt entry and CPUOFF low-power sleep. It sits between the instruction decoder / interrupt unit and the microcode ROM, and replaces the purely combinational next-CAR selection with a stateful controller. It also issues the interrupt-acknowledge handshake and flags uSeq overrun and bus-timeout faults.

---
 rtl/car_sequencer_pkg.sv | 32 +++
 rtl/car_next_sel.sv | 48 ++++
 rtl/car_sequencer.sv | 157 +++++++++++++++
 tb/tb_car_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/car_sequencer_pkg.sv
// Shared constants and state encoding for the microcode address sequencer.
package car_sequencer_pkg;

    localparam int CAR_BITS  = 6;
    localparam int WAIT_MAX  = 15;
    localparam int WAIT_BITS = $clog2(WAIT_MAX + 1);

    // Well-known microsequence entry points.
    localparam logic [CAR_BITS-1:0] CAR_0    = 6'd0;
    localparam logic [CAR_BITS-1:0] CAR_INT0 = 6'd56;
    localparam logic [CAR_BITS-1:0] CAR_INT4 = 6'd60;
    localparam logic [CAR_BITS-1:0] CAR_ONE  = 6'd1;
    localparam logic [CAR_BITS-1:0] CAR_MAX  = 6'd63;

    // Wait counter constants. The stall that reaches WAIT_MAX consecutive
    // mem_wait cycles times out, so the last tolerated count is WAIT_MAX-1.
    localparam logic [WAIT_BITS-1:0] WAIT_ZERO = 4'd0;
    localparam logic [WAIT_BITS-1:0] WAIT_ONE  = 4'd1;
    localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_SLEEP = 2'd2
    } seq_state_e;

    // True when incrementing the CAR would wrap to zero.
    function automatic logic car_is_max(input logic [CAR_BITS-1:0] car);
        return (car == CAR_MAX);
    endfunction

endpackage

// File: rtl/car_next_sel.sv
// Combinational priority mux choosing the next microcode address while the
// sequencer is running (or is releasing a stall and re-executing a micro-op).
module car_next_sel
    import car_sequencer_pkg::*;
(
    input  logic                rst,
    input  logic                br,
    input  logic                intreq,
    input  logic                if_strobe,
    input  logic                cpuoff,
    input  logic                in_int,
    input  logic [CAR_BITS-1:0] car,
    input  logic [CAR_BITS-1:0] car_new,
    output logic [CAR_BITS-1:0] car_next,
    output logic                take_int,
    output logic                take_sleep,
    output logic                clr_int,
    output logic                wrap
);

    // Priority: reset, branch-back, interrupt entry, sleep entry, fetch, increment.
    always_comb begin
        car_next   = car + CAR_ONE;
        take_int   = 1'b0;
        take_sleep = 1'b0;
        clr_int    = 1'b0;
        wrap       = 1'b0;
        if (rst) begin
            car_next = CAR_INT4;
        end else if (br) begin
            // Br also consumes any IF raised in the same micro-op.
            car_next = CAR_0;
            clr_int  = 1'b1;
        end else if (if_strobe && intreq && !in_int) begin
            car_next = CAR_INT0;
            take_int = 1'b1;
        end else if (if_strobe && cpuoff) begin
            car_next   = CAR_0;
            take_sleep = 1'b1;
        end else if (if_strobe) begin
            car_next = car_new;
        end else begin
            car_next = car + CAR_ONE;
            wrap     = car_is_max(car);
        end
    end

endmodule

// File: rtl/car_sequencer.sv
// Stateful Control Address Register sequencer: run / memory stall / sleep,
// interrupt-acknowledge handshake and sticky fault flags.
module car_sequencer
    import car_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                INTREQ,
    input  logic                IF,
    input  logic                Br,
    input  logic                cpuoff,
    input  logic                mem_wait,
    input  logic [CAR_BITS-1:0] CARnew,
    output logic [CAR_BITS-1:0] CAR,
    output logic                int_ack,
    output logic                sleeping,
    output logic                useq_err,
    output logic                bus_err
);

    seq_state_e            state_q, state_d;
    logic [CAR_BITS-1:0]   car_q, car_d;
    logic [WAIT_BITS-1:0]  wait_cnt_q, wait_cnt_d;
    logic                  in_int_q, in_int_d;
    logic                  int_ack_q, int_ack_d;
    logic                  sleeping_q, sleeping_d;
    logic                  useq_err_q, useq_err_d;
    logic                  bus_err_q, bus_err_d;

    logic [CAR_BITS-1:0]   sel_car_s;
    logic                  sel_take_int_s;
    logic                  sel_take_sleep_s;
    logic                  sel_clr_int_s;
    logic                  sel_wrap_s;

    car_next_sel u_next_sel (
        .rst        (rst),
        .br         (Br),
        .intreq     (INTREQ),
        .if_strobe  (IF),
        .cpuoff     (cpuoff),
        .in_int     (in_int_q),
        .car        (car_q),
        .car_new    (CARnew),
        .car_next   (sel_car_s),
        .take_int   (sel_take_int_s),
        .take_sleep (sel_take_sleep_s),
        .clr_int    (sel_clr_int_s),
        .wrap       (sel_wrap_s)
    );

    // Next-state, next-CAR and flag computation for the three sequencer states.
    always_comb begin
        state_d    = state_q;
        car_d      = car_q;
        wait_cnt_d = wait_cnt_q;
        in_int_d   = in_int_q;
        int_ack_d  = 1'b0;
        sleeping_d = sleeping_q;
        useq_err_d = useq_err_q;
        bus_err_d  = bus_err_q;
        case (state_q)
            ST_RUN, ST_STALL: begin
                if (mem_wait) begin
                    // Memory not ready: hold the CAR so the micro-op repeats.
                    if (state_q == ST_RUN) begin
                        state_d    = ST_STALL;
                        wait_cnt_d = WAIT_ONE;
                    end else if (wait_cnt_q >= WAIT_LAST) begin
                        // Bus timeout: abandon the micro-op and refetch.
                        bus_err_d  = 1'b1;
                        car_d      = CAR_0;
                        state_d    = ST_RUN;
                        wait_cnt_d = WAIT_ZERO;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_ONE;
                    end
                end else begin
                    // Memory ready: the current (possibly held) micro-op
                    // completes now, so its IF/Br drive the next address.
                    state_d    = ST_RUN;
                    wait_cnt_d = WAIT_ZERO;
                    car_d      = sel_car_s;
                    if (sel_clr_int_s) begin
                        in_int_d = 1'b0;
                    end else if (sel_take_int_s) begin
                        in_int_d  = 1'b1;
                        int_ack_d = 1'b1;
                    end else if (sel_take_sleep_s) begin
                        state_d    = ST_SLEEP;
                        sleeping_d = 1'b1;
                    end else begin
                        in_int_d = in_int_q;
                    end
                    if (sel_wrap_s) begin
                        useq_err_d = 1'b1;
                    end else begin
                        useq_err_d = useq_err_q;
                    end
                end
            end
            ST_SLEEP: begin
                // Fetch address parked; only interrupts or a debug wake leave.
                // An interrupt already in service cannot be acknowledged twice.
                car_d = CAR_0;
                if (INTREQ && !in_int_q) begin
                    car_d      = CAR_INT0;
                    int_ack_d  = 1'b1;
                    in_int_d   = 1'b1;
                    sleeping_d = 1'b0;
                    state_d    = ST_RUN;
                end else if (!cpuoff) begin
                    sleeping_d = 1'b0;
                    state_d    = ST_RUN;
                end else begin
                    sleeping_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                car_d      = CAR_0;
                wait_cnt_d = WAIT_ZERO;
                sleeping_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset to the reset-vector uSeq.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            car_q      <= CAR_INT4;
            wait_cnt_q <= WAIT_ZERO;
            in_int_q   <= 1'b0;
            int_ack_q  <= 1'b0;
            sleeping_q <= 1'b0;
            useq_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            car_q      <= car_d;
            wait_cnt_q <= wait_cnt_d;
            in_int_q   <= in_int_d;
            int_ack_q  <= int_ack_d;
            sleeping_q <= sleeping_d;
            useq_err_q <= useq_err_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign CAR      = car_q;
    assign int_ack  = int_ack_q;
    assign sleeping = sleeping_q;
    assign useq_err = useq_err_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_car_sequencer.sv
// Self-checking bench for car_sequencer: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_car_sequencer;

    localparam int T_WAIT_MAX = 15;

    logic       clk;
    logic       rst;
    logic       intreq;
    logic       if_s;
    logic       br;
    logic       cpuoff;
    logic       mem_wait;
    logic [5:0] car_new;
    logic [5:0] car;
    logic       int_ack;
    logic       sleeping;
    logic       useq_err;
    logic       bus_err;

    int n_cmp;
    int n_mis;

    // Behavioural model state
    logic [5:0] m_car;
    bit         m_asleep;
    bit         m_in_int;
    bit         m_ack;
    bit         m_uerr;
    bit         m_berr;
    int         m_waits;

    car_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .INTREQ   (intreq),
        .IF       (if_s),
        .Br       (br),
        .cpuoff   (cpuoff),
        .mem_wait (mem_wait),
        .CARnew   (car_new),
        .CAR      (car),
        .int_ack  (int_ack),
        .sleeping (sleeping),
        .useq_err (useq_err),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of the model using the inputs that were present at the edge.
    task automatic model_step();
        m_ack = 1'b0;
        if (rst) begin
            m_car = 6'd60; m_asleep = 1'b0; m_in_int = 1'b0;
            m_uerr = 1'b0; m_berr = 1'b0; m_waits = 0;
        end else if (m_asleep) begin
            m_car = 6'd0;
            if (intreq && !m_in_int) begin
                m_car = 6'd56; m_ack = 1'b1; m_in_int = 1'b1; m_asleep = 1'b0;
            end else if (!cpuoff) begin
                m_asleep = 1'b0;
            end
        end else if (mem_wait) begin
            m_waits = m_waits + 1;
            if (m_waits == T_WAIT_MAX) begin
                m_berr = 1'b1; m_car = 6'd0; m_waits = 0;
            end
        end else begin
            m_waits = 0;
            if (br) begin
                m_car = 6'd0; m_in_int = 1'b0;
            end else if (if_s && intreq && !m_in_int) begin
                m_car = 6'd56; m_ack = 1'b1; m_in_int = 1'b1;
            end else if (if_s && cpuoff) begin
                m_car = 6'd0; m_asleep = 1'b1;
            end else if (if_s) begin
                m_car = car_new;
            end else begin
                if (m_car == 6'd63) m_uerr = 1'b1;
                m_car = m_car + 6'd1;
            end
        end
    endtask

    // Apply the current inputs across one rising edge, then advance the model.
    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic set_in(input bit r, input bit iq, input bit f, input bit b,
                          input bit co, input bit mw, input logic [5:0] cn);
        rst = r; intreq = iq; if_s = f; br = b; cpuoff = co; mem_wait = mw; car_new = cn;
    endtask

    task automatic test_reset();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        tick(); tick();
        // Run into a stall, then reset in the middle of it.
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        tick(); tick();
        mem_wait = 1'b1;
        tick(); tick();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++;
            if (car !== 6'd60 || int_ack !== 1'b0 || sleeping !== 1'b0 ||
                useq_err !== 1'b0 || bus_err !== 1'b0) begin
                n_mis++;
                $display("FAIL reset[%0d] got car=%0d ack=%b slp=%b uerr=%b berr=%b exp car=60 flags=0",
                         k, car, int_ack, sleeping, useq_err, bus_err);
            end
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd12);
    endtask

    task automatic test_normal();
        logic [5:0] exp_seq [5];
        exp_seq = '{6'd61, 6'd62, 6'd63, 6'd12, 6'd13};
        for (int k = 0; k < 5; k++) begin
            if_s = (k == 3);
            tick();
            n_cmp++;
            if (car !== exp_seq[k]) begin
                n_mis++;
                $display("FAIL normal[%0d] got car=%0d exp %0d", k, car, exp_seq[k]);
            end
        end
        if_s = 1'b0;
    endtask

    task automatic test_interrupt();
        logic [5:0] exp_car [6];
        logic       exp_ack [6];
        exp_car = '{6'd20, 6'd56, 6'd57, 6'd30, 6'd0, 6'd56};
        exp_ack = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            intreq  = (k != 0);
            if_s    = (k != 2) && (k != 4);
            br      = (k == 4);
            car_new = (k == 0) ? 6'd20 : 6'd30;
            tick();
            n_cmp++;
            if (car !== exp_car[k] || int_ack !== exp_ack[k]) begin
                n_mis++;
                $display("FAIL interrupt[%0d] got car=%0d ack=%b exp car=%0d ack=%b",
                         k, car, int_ack, exp_car[k], exp_ack[k]);
            end
        end
        // Close the interrupt uSeq.
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd5);
        tick();
        n_cmp++;
        if (car !== 6'd0 || int_ack !== 1'b0) begin
            n_mis++;
            $display("FAIL int_close got car=%0d ack=%b exp car=0 ack=0", car, int_ack);
        end
        br = 1'b0;
    endtask

    task automatic test_stall();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5);
        tick();
        if_s = 1'b0;
        mem_wait = 1'b1;
        for (int k = 0; k < 3; k++) begin
            // IF/Br/INTREQ are ignored on the stall-entry cycle and while stalled.
            br = (k == 0); intreq = 1'b1; if_s = 1'b1;
            tick();
            n_cmp++;
            if (car !== 6'd5 || int_ack !== 1'b0) begin
                n_mis++;
                $display("FAIL stall_hold[%0d] got car=%0d ack=%b exp car=5 ack=0", k, car, int_ack);
            end
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd5);
        tick();
        n_cmp++;
        if (car !== 6'd6) begin
            n_mis++;
            $display("FAIL stall_release got car=%0d exp 6", car);
        end
        mem_wait = 1'b1;
        for (int k = 1; k <= T_WAIT_MAX; k++) begin
            tick();
            n_cmp++;
            if (k < T_WAIT_MAX && (car !== 6'd6 || bus_err !== 1'b0)) begin
                n_mis++;
                $display("FAIL timeout_wait[%0d] got car=%0d berr=%b exp car=6 berr=0", k, car, bus_err);
            end else if (k == T_WAIT_MAX && (car !== 6'd0 || bus_err !== 1'b1)) begin
                n_mis++;
                $display("FAIL timeout got car=%0d berr=%b exp car=0 berr=1", car, bus_err);
            end
        end
        mem_wait = 1'b0;
        tick();
        n_cmp++;
        if (car !== 6'd1 || bus_err !== 1'b1) begin
            n_mis++;
            $display("FAIL berr_sticky got car=%0d berr=%b exp car=1 berr=1", car, bus_err);
        end
    endtask

    task automatic test_sleep();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd33);
        tick();
        n_cmp++;
        if (car !== 6'd0 || sleeping !== 1'b1) begin
            n_mis++;
            $display("FAIL sleep_enter got car=%0d slp=%b exp car=0 slp=1", car, sleeping);
        end
        for (int k = 0; k < 20; k++) begin
            if_s = k[0]; br = k[1]; mem_wait = k[2];
            tick();
            n_cmp++;
            if (car !== 6'd0 || sleeping !== 1'b1 || int_ack !== 1'b0) begin
                n_mis++;
                $display("FAIL sleep_hold[%0d] got car=%0d slp=%b ack=%b exp car=0 slp=1 ack=0",
                         k, car, sleeping, int_ack);
            end
        end
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
        tick();
        n_cmp++;
        if (car !== 6'd56 || int_ack !== 1'b1 || sleeping !== 1'b0) begin
            n_mis++;
            $display("FAIL sleep_wake got car=%0d ack=%b slp=%b exp car=56 ack=1 slp=0",
                     car, int_ack, sleeping);
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
        tick();
        br = 1'b0;
    endtask

    task automatic test_wrap_priority();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd63);
        tick();
        if_s = 1'b0;
        n_cmp++;
        if (useq_err !== 1'b0) begin
            n_mis++;
            $display("FAIL uerr_pre got %b exp 0", useq_err);
        end
        tick();
        n_cmp++;
        if (car !== 6'd0 || useq_err !== 1'b1) begin
            n_mis++;
            $display("FAIL wrap got car=%0d uerr=%b exp car=0 uerr=1", car, useq_err);
        end
        tick();
        n_cmp++;
        if (car !== 6'd1 || useq_err !== 1'b1) begin
            n_mis++;
            $display("FAIL uerr_sticky got car=%0d uerr=%b exp car=1 uerr=1", car, useq_err);
        end
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd40);
        tick();
        n_cmp++;
        if (car !== 6'd0 || int_ack !== 1'b0) begin
            n_mis++;
            $display("FAIL br_priority got car=%0d ack=%b exp car=0 ack=0", car, int_ack);
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    endtask

    task automatic test_random();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        tick();
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            intreq   = ($urandom_range(0, 3) == 0);
            if_s     = ($urandom_range(0, 2) == 0);
            br       = ($urandom_range(0, 5) == 0);
            cpuoff   = ($urandom_range(0, 2) == 0);
            mem_wait = ((i % 400) >= 380) ? 1'b1 : ($urandom_range(0, 4) == 0);
            car_new  = 6'($urandom_range(0, 63));
            tick();
            n_cmp++;
            if (car !== m_car || int_ack !== m_ack || sleeping !== m_asleep ||
                useq_err !== m_uerr || bus_err !== m_berr) begin
                n_mis++;
                $display("FAIL random[%0d] got car=%0d ack=%b slp=%b uerr=%b berr=%b exp car=%0d ack=%b slp=%b uerr=%b berr=%b",
                         i, car, int_ack, sleeping, useq_err, bus_err,
                         m_car, m_ack, m_asleep, m_uerr, m_berr);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        m_car = 6'd60; m_asleep = 1'b0; m_in_int = 1'b0; m_ack = 1'b0;
        m_uerr = 1'b0; m_berr = 1'b0; m_waits = 0;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        test_reset();
        test_normal();
        test_interrupt();
        test_stall();
        test_sleep();
        test_wrap_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
